// File: rtl/issue_scheduler_pkg.sv
// Shared types for the dual-issue scheduler: decoded issue info and stage trackers.
// Register width is fixed here so the decoder and scheduler agree on packing.
package issue_scheduler_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    reg_idx_t rd;
    logic     wen;
    logic     long;    // load, mul/div, CSR read: forwardable from WB only
    logic     mem;
    logic     branch;
    logic     serial;
  } issue_info_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     long;
  } trk_t;

  // Only real register writes are tracked; r0 and non-writers never create hazards.
  function automatic trk_t mk_trk(input issue_info_t inst, input logic issued);
    trk_t t;
    t.valid = issued & inst.wen & (inst.rd != '0);
    t.rd    = inst.rd;
    t.long  = inst.long;
    return t;
  endfunction

endpackage

// File: rtl/issue_scheduler_reg_hazard_chk.sv
// Source-operand hazard check against the EX/M1 trackers; purely combinational.
// Only long-latency producers block, since ALU results forward from M1.
module reg_hazard_chk
  import issue_scheduler_pkg::*;
(
  input  reg_idx_t   src_i,
  input  trk_t [3:0] trk_i,
  output logic       blocked_o
);

  always_comb begin
    blocked_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((src_i != '0) && trk_i[i].valid && trk_i[i].long && (trk_i[i].rd == src_i)) begin
        blocked_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order dual-issue controller: issue_num_o is combinational, EX/M1 trackers update each edge.
// mem_stall_i freezes all state and issues nothing; the front end re-presents unconsumed slots.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter bit DUAL_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  issue_info_t [1:0] inst_i,
  input  logic [1:0]        inst_valid_i,
  input  logic              mem_stall_i,
  input  logic              flush_i,
  input  logic [1:0]        ex_kill_i,
  output logic [1:0]        issue_num_o,
  output logic              backend_stall_o,
  output logic [1:0]        ex_valid_o
);

  trk_t [1:0] ex_trk_q, ex_trk_d;
  trk_t [1:0] m1_trk_q, m1_trk_d;
  logic [1:0] ex_valid_q, ex_valid_d;

  trk_t [3:0] trk_all;
  logic [1:0] blk_rs1, blk_rs2;
  logic       pipe_busy;
  logic       intra_raw;
  logic       slot0_go, slot1_go;

  assign trk_all = {m1_trk_q, ex_trk_q};

  for (genvar s = 0; s < 2; s++) begin : g_slot
    reg_hazard_chk u_chk_rs1 (
      .src_i     (inst_i[s].rs1),
      .trk_i     (trk_all),
      .blocked_o (blk_rs1[s])
    );
    reg_hazard_chk u_chk_rs2 (
      .src_i     (inst_i[s].rs2),
      .trk_i     (trk_all),
      .blocked_o (blk_rs2[s])
    );
  end

  assign pipe_busy = ex_trk_q[0].valid | ex_trk_q[1].valid
                   | m1_trk_q[0].valid | m1_trk_q[1].valid;

  assign intra_raw = inst_i[0].wen && (inst_i[0].rd != '0)
                   && ((inst_i[0].rd == inst_i[1].rs1) || (inst_i[0].rd == inst_i[1].rs2));

  always_comb begin
    slot0_go = inst_valid_i[0] && !mem_stall_i && !flush_i
            && !blk_rs1[0] && !blk_rs2[0]
            && (!inst_i[0].serial || !pipe_busy);

    // A serial op in slot0 must go alone; a branch always closes its pair.
    slot1_go = slot0_go && DUAL_EN && inst_valid_i[1]
            && !blk_rs1[1] && !blk_rs2[1]
            && !intra_raw
            && !(inst_i[0].mem && inst_i[1].mem)
            && !inst_i[1].serial && !inst_i[0].serial
            && !inst_i[0].branch;

    issue_num_o = slot1_go ? 2'd2 : (slot0_go ? 2'd1 : 2'd0);
  end

  assign backend_stall_o = mem_stall_i | (inst_valid_i[0] & (issue_num_o == 2'd0));
  assign ex_valid_o      = ex_valid_q;

  always_comb begin
    ex_trk_d   = ex_trk_q;
    m1_trk_d   = m1_trk_q;
    ex_valid_d = ex_valid_q;
    if (!mem_stall_i) begin
      for (int i = 0; i < 2; i++) begin
        m1_trk_d[i]       = ex_trk_q[i];
        m1_trk_d[i].valid = ex_trk_q[i].valid & ~ex_kill_i[i];
      end
      ex_trk_d[0] = mk_trk(inst_i[0], slot0_go);
      ex_trk_d[1] = mk_trk(inst_i[1], slot1_go);
      ex_valid_d  = {slot1_go, slot0_go};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_trk_q   <= '0;
      m1_trk_q   <= '0;
      ex_valid_q <= '0;
    end else begin
      ex_trk_q   <= ex_trk_d;
      m1_trk_q   <= m1_trk_d;
      ex_valid_q <= ex_valid_d;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: single-cycle vector table from reset plus
// hand-written multi-cycle hazard sequences; a DUAL_EN=0 copy shares the stimulus.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  issue_info_t [1:0] inst;
  logic [1:0]        inst_valid;
  logic              mem_stall;
  logic              flush;
  logic [1:0]        ex_kill;
  logic [1:0]        issue_num, issue_num_sg;
  logic              backend_stall, backend_stall_sg;
  logic [1:0]        ex_valid, ex_valid_sg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  issue_scheduler #(.DUAL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst), .inst_valid_i(inst_valid),
    .mem_stall_i(mem_stall), .flush_i(flush), .ex_kill_i(ex_kill),
    .issue_num_o(issue_num), .backend_stall_o(backend_stall), .ex_valid_o(ex_valid)
  );

  issue_scheduler #(.DUAL_EN(1'b0)) dut_sg (
    .clk(clk), .rst_n(rst_n), .inst_i(inst), .inst_valid_i(inst_valid),
    .mem_stall_i(mem_stall), .flush_i(flush), .ex_kill_i(ex_kill),
    .issue_num_o(issue_num_sg), .backend_stall_o(backend_stall_sg), .ex_valid_o(ex_valid_sg)
  );

  function automatic issue_info_t mk(input int rd, input int rs1, input int rs2, input logic wen,
                                     input logic lng, input logic mem, input logic br,
                                     input logic ser);
    issue_info_t x;
    x.rd = reg_idx_t'(rd); x.rs1 = reg_idx_t'(rs1); x.rs2 = reg_idx_t'(rs2);
    x.wen = wen; x.long = lng; x.mem = mem; x.branch = br; x.serial = ser;
    return x;
  endfunction

  function automatic issue_info_t alu(input int rd, input int rs1, input int rs2);
    return mk(rd, rs1, rs2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic issue_info_t ld(input int rd, input int rs1);
    return mk(rd, rs1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic issue_info_t br(input int rs1, input int rs2);
    return mk(0, rs1, rs2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic issue_info_t csr(input int rd);
    return mk(rd, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    inst       = '0;
    inst_valid = 2'b00;
    mem_stall  = 1'b0;
    flush      = 1'b0;
    ex_kill    = 2'b00;
  endtask

  // Leaves the bench at posedge+1 with reset released and trackers empty.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Advance to the next active edge; inputs are then changed at posedge+1.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Comb outputs are sampled mid-cycle, well away from the active edge.
  task automatic chk_num(input string name, input int exp_num);
    #3;
    chk(name, 32'(issue_num), 32'(exp_num));
  endtask

  typedef struct {
    string       name;
    issue_info_t i0;
    issue_info_t i1;
    logic [1:0]  vld;
    logic        stall;
    logic        fl;
    int          exp_num;
    logic        exp_bs;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"alu_pair",     alu(1, 2, 0),  alu(3, 4, 0), 2'b11, 1'b0, 1'b0, 2, 1'b0};
    vecs[1]  = '{"raw_rs1",      alu(5, 1, 2),  alu(6, 5, 3), 2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[2]  = '{"raw_rs2",      alu(5, 1, 2),  alu(6, 3, 5), 2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[3]  = '{"waw_ok",       alu(5, 1, 2),  alu(5, 3, 4), 2'b11, 1'b0, 1'b0, 2, 1'b0};
    vecs[4]  = '{"two_loads",    ld(7, 1),      ld(8, 2),     2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[5]  = '{"load_alu",     ld(7, 1),      alu(8, 2, 3), 2'b11, 1'b0, 1'b0, 2, 1'b0};
    vecs[6]  = '{"branch_s0",    br(1, 2),      alu(3, 4, 5), 2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[7]  = '{"branch_s1",    alu(3, 4, 5),  br(1, 2),     2'b11, 1'b0, 1'b0, 2, 1'b0};
    vecs[8]  = '{"serial_s0",    csr(4),        alu(5, 6, 7), 2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[9]  = '{"serial_s1",    alu(5, 6, 7),  csr(4),       2'b11, 1'b0, 1'b0, 1, 1'b0};
    vecs[10] = '{"r0_no_raw",    alu(0, 1, 2),  alu(3, 0, 0), 2'b11, 1'b0, 1'b0, 2, 1'b0};
    vecs[11] = '{"vld_10",       alu(1, 2, 3),  alu(4, 5, 6), 2'b10, 1'b0, 1'b0, 0, 1'b0};
    vecs[12] = '{"vld_01",       alu(1, 2, 3),  alu(4, 5, 6), 2'b01, 1'b0, 1'b0, 1, 1'b0};
    vecs[13] = '{"mem_stall",    alu(1, 2, 3),  alu(4, 5, 6), 2'b11, 1'b1, 1'b0, 0, 1'b1};
    vecs[14] = '{"flush",        alu(1, 2, 3),  alu(4, 5, 6), 2'b11, 1'b0, 1'b1, 0, 1'b1};
    vecs[15] = '{"no_valid",     alu(1, 2, 3),  alu(4, 5, 6), 2'b00, 1'b0, 1'b0, 0, 1'b0};

    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_ex_valid_sg", 32'(ex_valid_sg), 32'd0);

    // Each vector starts from an empty pipe.
    for (int v = 0; v < 16; v++) begin
      int exp_sg;
      logic [1:0] exp_mask;
      do_reset();
      inst[0]    = vecs[v].i0;
      inst[1]    = vecs[v].i1;
      inst_valid = vecs[v].vld;
      mem_stall  = vecs[v].stall;
      flush      = vecs[v].fl;
      #3;
      exp_sg   = (vecs[v].exp_num > 1) ? 1 : vecs[v].exp_num;
      exp_mask = (vecs[v].exp_num == 2) ? 2'b11 : ((vecs[v].exp_num == 1) ? 2'b01 : 2'b00);
      chk({vecs[v].name, ".num"}, 32'(issue_num), 32'(vecs[v].exp_num));
      chk({vecs[v].name, ".stall"}, 32'(backend_stall), 32'(vecs[v].exp_bs));
      chk({vecs[v].name, ".num_single"}, 32'(issue_num_sg), 32'(exp_sg));
      nxt();
      chk({vecs[v].name, ".ex_valid"}, 32'(ex_valid), 32'(exp_mask));
    end

    // Intra-pair RAW: slot1 is re-presented alone and then issues.
    do_reset();
    inst[0] = alu(5, 1, 2); inst[1] = alu(6, 5, 3); inst_valid = 2'b11;
    chk_num("raw_seq.t0", 1);
    nxt();
    inst[0] = alu(6, 5, 3); inst[1] = '0; inst_valid = 2'b01;
    chk_num("raw_seq.t1", 1);
    chk("raw_seq.ex_valid_t1", 32'(ex_valid), 32'd1);

    // Load-use: two bubbles.
    do_reset();
    inst[0] = ld(7, 1); inst_valid = 2'b01;
    chk_num("ld_use.t0", 1);
    nxt();
    inst[0] = alu(8, 7, 2);
    chk_num("ld_use.t1", 0);
    nxt();
    chk_num("ld_use.t2", 0);
    chk("ld_use.bs_t2", 32'(backend_stall), 32'd1);
    nxt();
    chk_num("ld_use.t3", 1);
    chk("ld_use.bs_t3", 32'(backend_stall), 32'd0);

    // Load-use with a one-cycle memory stall at t+2.
    do_reset();
    inst[0] = ld(7, 1); inst_valid = 2'b01;
    chk_num("ld_stall.t0", 1);
    nxt();
    inst[0] = alu(8, 2, 7);
    chk_num("ld_stall.t1", 0);
    nxt();
    mem_stall = 1'b1;
    chk_num("ld_stall.t2", 0);
    nxt();
    mem_stall = 1'b0;
    chk_num("ld_stall.t3", 0);
    nxt();
    chk_num("ld_stall.t4", 1);

    // Serial op waits for the pipe to drain and then goes alone.
    do_reset();
    inst[0] = alu(1, 2, 3); inst_valid = 2'b01;
    chk_num("serial.t0", 1);
    nxt();
    inst[0] = csr(4); inst[1] = alu(5, 6, 7); inst_valid = 2'b11;
    chk_num("serial.t1", 0);
    nxt();
    chk_num("serial.t2", 0);
    nxt();
    chk_num("serial.t3", 1);

    // Kill + flush drop the load; its consumer then issues at once.
    do_reset();
    inst[0] = ld(9, 1); inst_valid = 2'b01;
    chk_num("kill.t0", 1);
    nxt();
    inst[0] = alu(10, 9, 2); flush = 1'b1; ex_kill = 2'b01;
    chk_num("kill.t1_flush", 0);
    nxt();
    flush = 1'b0; ex_kill = 2'b00;
    chk_num("kill.t2", 1);
    chk("kill.ex_valid_t2", 32'(ex_valid), 32'd0);

    // Load to r0 is never tracked.
    do_reset();
    inst[0] = ld(0, 1); inst_valid = 2'b01;
    chk_num("r0_load.t0", 1);
    nxt();
    inst[0] = alu(3, 0, 0);
    chk_num("r0_load.t1", 1);

    // Asynchronous reset mid-hazard forgets the pending load.
    do_reset();
    inst[0] = ld(11, 1); inst_valid = 2'b01;
    chk_num("arst.t0", 1);
    nxt();
    inst[0] = alu(12, 11, 0);
    chk_num("arst.t1", 0);
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    chk("arst.after", 32'(issue_num), 32'd1);
    chk("arst.ex_valid", 32'(ex_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
